cache_mem_model: RTL

CACHE_MEM_MODEL -- requirements
Module: cache_mem_model

---
 rtl/cache_ctrl_pkg.sv | 19 +
 rtl/cache_mem_model.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the line-oriented memory model: controller state encoding
// and the helper that sizes the in-line byte offset field.
package cache_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      BURST  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int BYTE_W = 8;

   // Number of address bits that select a byte within one line.
   function automatic int beat_off_bits(input int words, input int data_w);
      return $clog2((words * data_w) / BYTE_W);
   endfunction

endpackage

// File: rtl/cache_mem_model.sv
// Line-granular backing memory with fixed access latency: whole-line writes,
// reads returned as a WORDS-beat burst with valid/ready backpressure.
module cache_mem_model
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int WORDS      = 4,
   parameter int LAT        = 3,
   parameter int LINES_LOG2 = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [WORDS*DATA_W-1:0] req_wline,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_W-1:0]       resp_data,
   output logic                    resp_last,
   output logic                    wr_done,
   output logic                    err_misalign,
   output logic [15:0]             rd_count,
   output logic [15:0]             wr_count,
   output state_t                  state_dbg
);

   // Handshakes: a request transfers on the rising edge where req_valid and
   // req_ready are both high; a read beat transfers where resp_valid and
   // resp_ready are both high. resp_data/resp_last hold while resp_ready is low.

   localparam int OFF_W  = beat_off_bits(WORDS, DATA_W);
   localparam int BEAT_W = $clog2(WORDS);
   localparam int LINE_W = WORDS * DATA_W;
   localparam int LINES  = 1 << LINES_LOG2;
   localparam logic [3:0]        LAT_INIT  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   state_t                  state, state_nx;
   logic [3:0]              lat_cnt;
   logic [BEAT_W-1:0]       beat;
   logic                    cur_we;
   logic [LINES_LOG2-1:0]   cur_idx;
   logic [LINE_W-1:0]       cur_wline;
   logic [LINE_W-1:0]       rd_line;
   logic                    accept;
   logic                    misalign_hit;
   logic [LINES_LOG2-1:0]   req_idx;
   logic [ADDR_W+LINES_LOG2-1:0] addr_ext;
   logic                    unused_addr_bits;

   logic [LINE_W-1:0] mem [LINES] = '{default: '0};

   // Zero-extend before shifting so narrow address widths still give a full index.
   assign addr_ext         = {{LINES_LOG2{1'b0}}, req_addr} >> OFF_W;
   assign req_idx          = addr_ext[LINES_LOG2-1:0];
   assign unused_addr_bits = ^addr_ext[ADDR_W+LINES_LOG2-1:LINES_LOG2];
   assign misalign_hit     = |req_addr[OFF_W-1:0];
   assign accept           = req_valid && req_ready;
   assign rd_line          = mem[cur_idx];
   assign state_dbg        = state;

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_data  = '0;
      wr_done    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            if (accept) begin
               if (LAT > 0)     state_nx = WAIT;
               else if (req_we) state_nx = COMMIT;
               else             state_nx = BURST;
            end
         end
         WAIT: begin
            if (lat_cnt == 4'd0) state_nx = cur_we ? COMMIT : BURST;
         end
         BURST: begin
            resp_valid = 1'b1;
            resp_data  = rd_line[int'(beat)*DATA_W +: DATA_W];
            resp_last  = (beat == LAST_BEAT);
            if (resp_ready && resp_last) state_nx = IDLE;
         end
         COMMIT: begin
            wr_done  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lat_cnt      <= 4'd0;
         beat         <= '0;
         cur_we       <= 1'b0;
         cur_idx      <= '0;
         cur_wline    <= '0;
         err_misalign <= 1'b0;
         rd_count     <= 16'd0;
         wr_count     <= 16'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cur_we    <= req_we;
            cur_idx   <= req_idx;
            cur_wline <= req_wline;
            lat_cnt   <= LAT_INIT;
            beat      <= '0;
            if (misalign_hit) err_misalign <= 1'b1;
            if (req_we) begin
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
               if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
         end
         if (state == WAIT && lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
         if (state == BURST && resp_ready) beat <= beat + BEAT_W'(1);
      end
   end

   // The store is deliberately not reset; a reset during COMMIT abandons the write.
   always_ff @(posedge clk) begin
      if (!rst && state == COMMIT) mem[cur_idx] <= cur_wline;
   end

endmodule
